// File: rtl/arb_req_queue.sv
// arb_req_queue
//   Per-lane pending-request queue in front of a 4-way arbiter. Each lane
//   keeps a saturating pending count (0..DEPTH) fed by single-cycle request
//   pulses and drained by one legal grant per cycle. Drives the arbiter's
//   level request, flags dropped requests (sticky), bad grants (pulse) and,
//   optionally, starvation.
//
//   Optional feature macro: STARVE_MON_EN (per-lane wait counters and the
//   starve output). Without it, starve is tied low and no counters exist.
//
// Ports
//   clk      in   clock, all state on rising edge
//   rst      in   asynchronous active-low reset
//   req_in   in   [3:0] per-lane request pulse (one request per high cycle)
//   gnt      in   [3:0] grant from arbiter, expected one-hot or zero
//   clr_ovf  in   synchronous clear of the overflow sticky bits
//   req      out  [3:0] lane has pending requests
//   full     out  [3:0] lane count equals DEPTH
//   overflow out  [3:0] sticky, a request was dropped on the lane
//   gnt_err  out  one-cycle pulse after a multi-hot or spurious grant
//   pend_cnt out  [4*CNT_W-1:0] lane i count at [i*CNT_W +: CNT_W]
//   starve   out  [3:0] lane waited STARVE_LIMIT cycles without a grant
module arb_req_queue #(
  parameter int DEPTH        = 8,
  parameter int CNT_W        = $clog2(DEPTH + 1),
  parameter int STARVE_LIMIT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req_in,
  input  logic [3:0]         gnt,
  input  logic               clr_ovf,
  output logic [3:0]         req,
  output logic [3:0]         full,
  output logic [3:0]         overflow,
  output logic               gnt_err,
  output logic [4*CNT_W-1:0] pend_cnt,
  output logic [3:0]         starve
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("arb_req_queue: DEPTH must be at least 1");
  end
  if (STARVE_LIMIT < 2) begin : g_bad_limit
    $error("arb_req_queue: STARVE_LIMIT must be at least 2");
  end

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       ovf_q, ovf_d;
  logic             gnt_err_q, gnt_err_d;

  logic [3:0] lane_nz;
  logic       gnt_onehot;
  logic [3:0] dec;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      lane_nz[i] = (cnt_q[i] != '0);
    end
  end

  // A grant only retires a request when it is one-hot and hits a non-empty
  // lane. With that, dec is zero for every bad grant, so the error is simply
  // "some grant bit set but nothing retired".
  assign gnt_onehot = (gnt != '0) && ((gnt & (gnt - 4'd1)) == '0);
  assign dec        = gnt_onehot ? (gnt & lane_nz) : '0;
  assign gnt_err_d  = (gnt != '0) && (dec == '0);

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      // Set has priority over clear.
      ovf_d[i] = ovf_q[i] & ~clr_ovf;
      if (req_in[i] && !dec[i]) begin
        if (cnt_q[i] == DEPTH_C) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (!req_in[i] && dec[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q     <= '0;
      gnt_err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ovf_q     <= ovf_d;
      gnt_err_q <= gnt_err_d;
    end
  end

  always_comb begin
    pend_cnt = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      req[i]                       = lane_nz[i];
      full[i]                      = (cnt_q[i] == DEPTH_C);
      pend_cnt[i*CNT_W +: CNT_W]   = cnt_q[i];
    end
  end

  assign overflow = ovf_q;
  assign gnt_err  = gnt_err_q;

`ifdef STARVE_MON_EN
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] LIMIT_C = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] wait_q [4];
  logic [WAIT_W-1:0] wait_d [4];

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      wait_d[i] = wait_q[i];
      if (!lane_nz[i] || dec[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != LIMIT_C) begin
        wait_d[i] = wait_q[i] + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        wait_q[i] <= wait_d[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      starve[i] = (wait_q[i] == LIMIT_C);
    end
  end
`else
  assign starve = '0;
`endif

endmodule

// File: tb/tb_arb_req_queue.sv
// Self-checking bench for arb_req_queue: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a lane-count model.
module tb_arb_req_queue;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int LIMIT = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [3:0]         req_in = '0;
  logic [3:0]         gnt = '0;
  logic               clr_ovf = 1'b0;
  logic [3:0]         req;
  logic [3:0]         full;
  logic [3:0]         overflow;
  logic               gnt_err;
  logic [4*CNT_W-1:0] pend_cnt;
  logic [3:0]         starve;

  arb_req_queue #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .gnt      (gnt),
    .clr_ovf  (clr_ovf),
    .req      (req),
    .full     (full),
    .overflow (overflow),
    .gnt_err  (gnt_err),
    .pend_cnt (pend_cnt),
    .starve   (starve)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer counts per lane.
  int m_cnt  [4];
  bit m_ovf  [4];
  bit m_err;
  int m_wait [4];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i]  = 0;
      m_ovf[i]  = 0;
      m_wait[i] = 0;
    end
    m_err = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] g, input logic c);
    bit [3:0] d;
    d = '0;
    if ($countones(g) == 1) begin
      for (int i = 0; i < 4; i++) if (g[i] && m_cnt[i] > 0) d[i] = 1'b1;
    end
    m_err = (g != 0) && (d == 0);
    for (int i = 0; i < 4; i++) begin
      if (m_cnt[i] == 0 || d[i]) m_wait[i] = 0;
      else if (m_wait[i] < LIMIT) m_wait[i] = m_wait[i] + 1;
      m_ovf[i] = (r[i] && !d[i] && m_cnt[i] == DEPTH) || (m_ovf[i] && !c);
      if (r[i] && !d[i] && m_cnt[i] < DEPTH) m_cnt[i] = m_cnt[i] + 1;
      else if (!r[i] && d[i]) m_cnt[i] = m_cnt[i] - 1;
    end
  endtask

  task automatic check_model();
    logic [15:0] e_pend;
    logic [3:0]  e_req, e_full, e_ovf, e_st;
    for (int i = 0; i < 4; i++) begin
      e_pend[i*4 +: 4] = 4'(m_cnt[i]);
      e_req[i]  = (m_cnt[i] != 0);
      e_full[i] = (m_cnt[i] == DEPTH);
      e_ovf[i]  = m_ovf[i];
`ifdef STARVE_MON_EN
      e_st[i]   = (m_wait[i] == LIMIT);
`else
      e_st[i]   = 1'b0;
`endif
    end
    chk("model pend_cnt", 32'(pend_cnt), 32'(e_pend));
    chk("model req",      32'(req),      32'(e_req));
    chk("model full",     32'(full),     32'(e_full));
    chk("model overflow", 32'(overflow), 32'(e_ovf));
    chk("model gnt_err",  32'(gnt_err),  32'(m_err));
    chk("model starve",   32'(starve),   32'(e_st));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs checked 1 unit
  // after the next rising edge.
  task automatic step(input logic [3:0] r, input logic [3:0] g, input logic c);
    req_in  = r;
    gnt     = g;
    clr_ovf = c;
    @(posedge clk);
    model_step(r, g, c);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    req_in  = '0;
    gnt     = '0;
    clr_ovf = 1'b0;
    rst     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  r;
    logic [3:0]  g;
    logic        c;
    logic [15:0] e_pend;
    logic [3:0]  e_req;
    logic        e_err;
  } vec_t;

  vec_t vt [13];
  logic [3:0] rr, gg;
  int sel;

  initial begin
    vt[0]  = '{4'b0100, 4'b0000, 1'b0, 16'h0100, 4'b0100, 1'b0};
    vt[1]  = '{4'b0100, 4'b0000, 1'b0, 16'h0200, 4'b0100, 1'b0};
    vt[2]  = '{4'b0100, 4'b0000, 1'b0, 16'h0300, 4'b0100, 1'b0};
    vt[3]  = '{4'b0000, 4'b0100, 1'b0, 16'h0200, 4'b0100, 1'b0};
    vt[4]  = '{4'b0000, 4'b0100, 1'b0, 16'h0100, 4'b0100, 1'b0};
    vt[5]  = '{4'b0000, 4'b0100, 1'b0, 16'h0000, 4'b0000, 1'b0};
    vt[6]  = '{4'b0000, 4'b1000, 1'b0, 16'h0000, 4'b0000, 1'b1};
    vt[7]  = '{4'b0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0};
    vt[8]  = '{4'b0011, 4'b0000, 1'b0, 16'h0011, 4'b0011, 1'b0};
    vt[9]  = '{4'b0000, 4'b0011, 1'b0, 16'h0011, 4'b0011, 1'b1};
    vt[10] = '{4'b0000, 4'b0000, 1'b0, 16'h0011, 4'b0011, 1'b0};
    vt[11] = '{4'b0000, 4'b0001, 1'b0, 16'h0010, 4'b0010, 1'b0};
    vt[12] = '{4'b0000, 4'b0010, 1'b0, 16'h0000, 4'b0000, 1'b0};

    do_reset();
    chk("reset pend_cnt", 32'(pend_cnt), 32'h0);
    chk("reset req",      32'(req),      32'h0);
    chk("reset flags",    32'({full, overflow, gnt_err, starve}), 32'h0);

    // Directed vectors: drain, spurious grant, multi-hot grant.
    for (int k = 0; k < 13; k++) begin
      step(vt[k].r, vt[k].g, vt[k].c);
      chk($sformatf("tbl%0d pend", k), 32'(pend_cnt), 32'(vt[k].e_pend));
      chk($sformatf("tbl%0d req", k),  32'(req),      32'(vt[k].e_req));
      chk($sformatf("tbl%0d err", k),  32'(gnt_err),  32'(vt[k].e_err));
    end

    // Overflow on lane 0, clear, set-wins-over-clear.
    do_reset();
    repeat (8) step(4'b0001, 4'b0000, 1'b0);
    chk("fill full",     32'(full),     32'h1);
    chk("fill no ovf",   32'(overflow), 32'h0);
    step(4'b0001, 4'b0000, 1'b0);
    chk("ovf set",       32'(overflow), 32'h1);
    chk("ovf cnt held",  32'(pend_cnt), 32'h8);
    step(4'b0000, 4'b0000, 1'b1);
    chk("ovf cleared",   32'(overflow), 32'h0);
    chk("clr cnt held",  32'(pend_cnt), 32'h8);
    step(4'b0001, 4'b0000, 1'b1);
    chk("set wins",      32'(overflow), 32'h1);
    step(4'b0000, 4'b0000, 1'b1);

    // Lane 1 full: simultaneous request and grant is accepted.
    repeat (8) step(4'b0010, 4'b0000, 1'b0);
    step(4'b0010, 4'b0010, 1'b0);
    chk("inc+dec cnt",   32'(pend_cnt[7:4]), 32'h8);
    chk("inc+dec ovf",   32'(overflow[1]),   32'h0);
    chk("inc+dec err",   32'(gnt_err),       32'h0);
    step(4'b0000, 4'b0010, 1'b0);
    chk("dec from full", 32'(pend_cnt[7:4]), 32'h7);

    // Asynchronous reset between edges.
    do_reset();
    step(4'b1111, 4'b0000, 1'b0);
    chk("all lanes req", 32'(req), 32'hf);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async req",  32'(req),      32'h0);
    chk("async full", 32'(full),     32'h0);
    chk("async pend", 32'(pend_cnt), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(4'b0001, 4'b0000, 1'b0);
    chk("post-reset cnt", 32'(pend_cnt), 32'h1);

`ifdef STARVE_MON_EN
    do_reset();
    step(4'b1000, 4'b0000, 1'b0);
    repeat (3) step(4'b0000, 4'b0000, 1'b0);
    chk("starve not yet", 32'(starve), 32'h0);
    step(4'b0000, 4'b0000, 1'b0);
    chk("starve rise",    32'(starve), 32'h8);
    step(4'b0000, 4'b0000, 1'b0);
    chk("starve hold",    32'(starve), 32'h8);
    step(4'b0000, 4'b1000, 1'b0);
    chk("starve clear",   32'(starve), 32'h0);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      rr  = 4'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 5)      gg = 4'b0001 << $urandom_range(0, 3);
      else if (sel < 7) gg = 4'b0000;
      else              gg = 4'($urandom);
      step(rr, gg, ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
